// File: rtl/uart_tx_scheduler_if.sv
// CPU-store / uart transmitter handshake for uart_tx_scheduler.
// The master drives store bytes; the slave (scheduler) returns stall and launches bytes.
interface uart_tx_scheduler_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       stall;
  logic       uart_wr;
  logic [7:0] uart_dat;

  modport master (output wr_en, wr_data, input stall, uart_wr, uart_dat);
  modport slave  (input wr_en, wr_data, output stall, uart_wr, uart_dat);
endinterface

// File: rtl/uart_tx_scheduler.sv
// Buffers CPU store bytes and paces one uart_wr pulse per FRAME_CYCLES.
// Optional UART_SCHED_STATS_EN builds the 32-bit launched-byte counter tx_count.
module uart_tx_scheduler #(
  parameter int FIFO_DEPTH   = 16,
  parameter int FRAME_CYCLES = 8680
) (
  input  logic                          clk,
  input  logic                          reset,
  uart_tx_scheduler_if.slave            bus,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [31:0]                   tx_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(FRAME_CYCLES);

  typedef enum logic {IDLE, GAP} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [TW-1:0]   timer;
  logic            full, push, launch;

  assign full       = (count == CW'(FIFO_DEPTH));
  assign push       = bus.wr_en && !full;
  assign bus.stall  = full;
  assign fifo_count = count;
  assign busy       = (state == GAP) || (count != '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (launch) state_nxt = GAP;
      GAP:  if (timer == '0 && !launch) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: launch whenever a byte is queued and the frame gap has elapsed
  always_comb begin
    launch = 1'b0;
    case (state)
      IDLE:    launch = (count != '0);
      GAP:     launch = (count != '0) && (timer == '0);
      default: launch = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      timer        <= '0;
      overflow     <= 1'b0;
      bus.uart_wr  <= 1'b0;
      bus.uart_dat <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (bus.wr_en && full) overflow <= 1'b1;
      case ({push, launch})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Head is read from the pre-edge memory, so a same-cycle push is never launched
      if (launch) begin
        bus.uart_wr  <= 1'b1;
        bus.uart_dat <= mem[rd_ptr];
        rd_ptr       <= rd_ptr + 1'b1;
        timer        <= TW'(FRAME_CYCLES - 1);
      end else begin
        bus.uart_wr <= 1'b0;
        if (timer != '0) timer <= timer - 1'b1;
      end
    end
  end

`ifdef UART_SCHED_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       tx_count <= '0;
    else if (launch) tx_count <= tx_count + 32'd1;
  end
`else
  assign tx_count = 32'h0;
`endif
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler (FIFO_DEPTH=4, FRAME_CYCLES=4) with a byte scoreboard.
module tb_uart_tx_scheduler;
  localparam int DEPTH = 4;
  localparam int FRAME = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        busy, overflow;
  logic [2:0]  fifo_count;
  logic [31:0] tx_count;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          npulses = 0;
  int          last_pulse = 0;
  bit          have_last = 1'b0;
  logic [7:0]  sb[$];

  uart_tx_scheduler_if bus ();

  uart_tx_scheduler #(.FIFO_DEPTH(DEPTH), .FRAME_CYCLES(FRAME)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .busy(busy),
    .fifo_count(fifo_count), .overflow(overflow), .tx_count(tx_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every pulse must match the scoreboard head and respect frame spacing
  always @(negedge clk) begin
    if (reset) begin
      have_last = 1'b0;
      npulses   = 0;
    end else if (bus.uart_wr === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {24'h0, bus.uart_dat}, 32'hffff_ffff);
      end else begin
        chk("pulse_data", {24'h0, bus.uart_dat}, {24'h0, sb.pop_front()});
      end
      if (have_last) chk("pulse_spacing_ok", 32'(cyc - last_pulse >= FRAME), 32'd1);
      have_last  = 1'b1;
      last_pulse = cyc;
      npulses++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    step();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, sb.size(), 0);
    repeat (FRAME + 2) step();
  endtask

  function automatic logic [31:0] exp_tx(input int n);
`ifdef UART_SCHED_STATS_EN
    return 32'(n);
`else
    return 32'(n) & 32'h0;
`endif
  endfunction

  initial begin
    int sent;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    #1;
    do_reset();
    chk("reset_uart_wr", bus.uart_wr, 0);
    chk("reset_uart_dat", bus.uart_dat, 8'h00);
    chk("reset_count", fifo_count, 0);
    chk("reset_busy", busy, 0);
    chk("reset_stall", bus.stall, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_tx_count", tx_count, 0);

    // Single byte: written in cycle 0, launched in cycle 2, busy drops in cycle 6
    bus.wr_en = 1'b1; bus.wr_data = 8'h41; sb.push_back(8'h41);
    step(); bus.wr_en = 1'b0;
    chk("single_c1_count", fifo_count, 1);
    chk("single_c1_wr", bus.uart_wr, 0);
    chk("single_c1_busy", busy, 1);
    step();
    chk("single_c2_wr", bus.uart_wr, 1);
    chk("single_c2_dat", bus.uart_dat, 8'h41);
    chk("single_c2_count", fifo_count, 0);
    step();
    chk("single_c3_wr", bus.uart_wr, 0);
    chk("single_c3_dat_hold", bus.uart_dat, 8'h41);
    step(); step();
    chk("single_c5_busy", busy, 1);
    step();
    chk("single_c6_busy", busy, 0);

    // Burst: pulses in cycles 2, 6, 10
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(i); sb.push_back(8'(i));
      step();
    end
    bus.wr_en = 1'b0;
    chk("burst_c3_wr", bus.uart_wr, 0);
    step(); step(); step();
    chk("burst_c6_wr", bus.uart_wr, 1);
    chk("burst_c6_dat", bus.uart_dat, 8'h02);
    repeat (4) step();
    chk("burst_c10_wr", bus.uart_wr, 1);
    chk("burst_c10_dat", bus.uart_dat, 8'h03);
    step();
    chk("burst_tx_count", tx_count, exp_tx(3));
    chk("burst_sb_empty", sb.size(), 0);

    // Full / overflow: six writes into a 4-deep FIFO
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(i);
      if (i <= 5) sb.push_back(8'(i));
      if (i == 5) chk("full_c4_stall", bus.stall, 0);
      if (i == 6) begin
        chk("full_c5_stall", bus.stall, 1);
        chk("full_c5_overflow", overflow, 0);
      end
      step();
    end
    bus.wr_en = 1'b0;
    chk("full_c6_overflow", overflow, 1);
    chk("full_c6_stall", bus.stall, 0);
    drain("full_drain", 40);
    chk("full_overflow_sticky", overflow, 1);
    chk("full_pulses", npulses, 5);

    // Pointer wrap: 12 bytes, writes gated by stall
    do_reset();
    sent = 0;
    for (int n = 0; n < 200 && sent < 12; n++) begin
      if (!bus.stall) begin
        bus.wr_en = 1'b1; bus.wr_data = 8'(8'h10 + sent);
        sb.push_back(8'(8'h10 + sent));
        sent++;
      end else begin
        bus.wr_en = 1'b0;
      end
      step();
    end
    bus.wr_en = 1'b0;
    chk("wrap_sent", sent, 12);
    drain("wrap_drain", 80);
    chk("wrap_pulses", npulses, 12);
    chk("wrap_overflow", overflow, 0);
    chk("wrap_tx_count", tx_count, exp_tx(12));

    // Reset one cycle after the second pulse of a 3-byte burst
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h60 + i); sb.push_back(8'(8'h60 + i));
      step();
    end
    bus.wr_en = 1'b0;
    repeat (3) step();
    chk("rst_mid_c6_wr", bus.uart_wr, 1);
    step();
    reset = 1'b1;
    #1;
    chk("rst_mid_uart_wr", bus.uart_wr, 0);
    chk("rst_mid_uart_dat", bus.uart_dat, 8'h00);
    chk("rst_mid_count", fifo_count, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_tx_count", tx_count, 0);
    sb.delete();
    step();
    reset = 1'b0;
    repeat (30) step();
    chk("rst_mid_no_pulse", npulses, 0);
    chk("rst_mid_idle_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Byte-transmit scheduler between the CPU store path and the `uart` transmitter. It buffers bytes stored to `UART_ADDR` in a small FIFO and issues one `uart_wr_i` pulse per byte, spaced by a fixed frame time, because `uart` has no busy output. It raises `stall` when the FIFO is full so the single-cycle CPU holds the store. It sits in `cpu` between the store decode (`w_store_addr == UART_ADDR && is_store`) and `uart0`.

## Interface
Parameters:
- `FIFO_DEPTH`, default 16: FIFO entries; power of two, ≥2.
- `FRAME_CYCLES`, default 8680: minimum clocks between consecutive `uart_wr` pulses (10 bits × clocks-per-bit); ≥2.

Ports:
- `clk`  in  1  system clock (`sysclk`); all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  CPU stores a byte to `UART_ADDR` this cycle.
- `wr_data`  in  8  byte to send (`w_data_byte`).
- `stall`  out  1  FIFO full; combinational, equals `fifo_count == FIFO_DEPTH`.
- `uart_wr`  out  1  registered one-cycle launch pulse to `uart_wr_i`.
- `uart_dat`  out  8  registered byte to `uart_dat_i`; valid while `uart_wr` is high, holds its value otherwise.
- `busy`  out  1  combinational; high when state is GAP or `fifo_count != 0`.
- `fifo_count`  out  log2(FIFO_DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; set when a write is dropped.
- `tx_count`  out  32  bytes launched (see Configuration).

## Operation
- FIFO: circular buffer, read and write pointers of log2(FIFO_DEPTH) bits that wrap modulo depth, plus an occupancy counter.
  - Push when `wr_en && !full`.
  - When `wr_en && full`, the byte is dropped and `overflow` is set. This holds even if a pop occurs in the same cycle. `overflow` clears only on reset.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- FSM, two states:
  - IDLE: if `fifo_count != 0`, then at the clock edge `uart_wr`←1, `uart_dat`←head, pop, `timer`←FRAME_CYCLES−1, go to GAP. Otherwise stay, with `uart_wr`←0.
  - GAP: `uart_wr`←0 unless a launch occurs.
    - If `timer != 0`: `timer` decrements.
    - If `timer == 0` and the FIFO is non-empty: launch as in IDLE and stay in GAP.
    - If `timer == 0` and the FIFO is empty: go to IDLE.
- `timer` width is ceil(log2(FRAME_CYCLES)) bits and never underflows.
- The head byte is read from the FIFO before the same-cycle push, so a write to an empty FIFO is not launched in the cycle it is written.
- Reset, asynchronous, at any time including mid-frame:
  - pointers, `fifo_count`, `timer` = 0; state = IDLE.
  - `uart_wr` = 0, `uart_dat` = 8'h00, `overflow` = 0, `tx_count` = 0.
  - Pending bytes are discarded.

## Timing
- Write sampled at the end of cycle N into an empty FIFO with the FSM in IDLE:
  - `fifo_count` = 1 in cycle N+1.
  - `uart_wr` high in cycle N+2 with `uart_dat` = byte; `fifo_count` = 0 in cycle N+2.
- Back-to-back bytes: if pulse k is in cycle P, pulse k+1 is in cycle P+FRAME_CYCLES, provided the next byte was present by cycle P+FRAME_CYCLES−1.
- `uart_wr` is never high in two consecutive cycles.
- `stall` asserts in the cycle after the push that fills the FIFO. It deasserts in the cycle after the pop that frees a slot.

## Configuration
- `UART_SCHED_STATS_EN` defined: `tx_count` is a 32-bit counter that increments on every `uart_wr` pulse and wraps from 32'hFFFF_FFFF to 0.
- `UART_SCHED_STATS_EN` undefined: no counter logic is built and `tx_count` is tied to 32'h0.

## Test plan
All scenarios use `FRAME_CYCLES`=4 and `FIFO_DEPTH`=4 overrides.
- Single byte: `wr_en` with 8'h41 in cycle 0 → `uart_wr`=1 with `uart_dat`=8'h41 in cycle 2 only; `busy` drops in cycle 6.
- Burst: 8'h01–8'h03 written in cycles 0–2 → pulses in cycles 2, 6, 10 carrying 8'h01, 8'h02, 8'h03 in order.
- Full/overflow: 6 writes in cycles 0–5 → `stall` high from cycle 5; pulses carry 8'h01–8'h05 (the cycle-2 pop frees the slot for byte 5); the sixth byte is dropped and `overflow`=1.
- Pointer wrap: 12 writes with `wr_en` gated by `!stall` → all 12 bytes are emitted in order with no loss and `overflow` stays 0.
- Reset mid-operation: assert `reset` one cycle after the second pulse of a 3-byte burst → all outputs take their reset values immediately; no further pulse occurs after release.
- Stats (with `UART_SCHED_STATS_EN`): after the burst scenario, `tx_count`=3. Without the macro, `tx_count`=0 throughout.
